// File: rtl/v810_icache_pkg.sv
// Shared types, geometry and address-field helpers for the V810 instruction cache.
package v810_icache_pkg;

    localparam int unsigned IDX_W          = 7;
    localparam int unsigned TAG_W          = 32 - IDX_W - 3;
    localparam int unsigned WADDR_W        = 30;
    localparam int unsigned NUM_LINES      = 1 << IDX_W;
    localparam int unsigned LINE_BYTES     = 8;
    localparam int unsigned WORDS_PER_LINE = 2;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        FILL
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]          tag;
        logic [WORDS_PER_LINE-1:0] v;
    } tag_entry_t;

    // Line index: byte-address bits [IDX_W+2:3].
    function automatic logic [IDX_W-1:0] addr_idx(input logic [WADDR_W-1:0] a);
        return a[IDX_W:1];
    endfunction

    // Tag: byte-address bits [31:IDX_W+3].
    function automatic logic [TAG_W-1:0] addr_tag(input logic [WADDR_W-1:0] a);
        return a[WADDR_W-1:IDX_W+1];
    endfunction

    // Word within the line: byte-address bit 2.
    function automatic logic addr_word(input logic [WADDR_W-1:0] a);
        return a[0];
    endfunction

    // Data store index: byte-address bits [IDX_W+2:2].
    function automatic logic [IDX_W:0] addr_didx(input logic [WADDR_W-1:0] a);
        return a[IDX_W:0];
    endfunction

endpackage

// File: rtl/v810_tagram.sv
// Asynchronous-read, synchronous-write RAM used for both tag and data stores.
module v810_tagram #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write port, clocked.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/v810_icache_ctl.sv
// V810 instruction cache controller: hit path, single-word miss fills, invalidation sweep.
module v810_icache_ctl
    import v810_icache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_en,
    input  logic        clr_req,
    output logic        clr_busy,
    input  logic        fetch_req,
    input  logic [29:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] fetch_data,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        clr_cnt_q;
    logic                    clr_pend_q, clr_pend_d;
    logic [WADDR_W-1:0]      lat_addr_q;
    logic [WADDR_W-1:0]      look_addr;
    logic                    start_fill;
    logic                    hit;
    logic                    ack;
    logic [WORDS_PER_LINE-1:0] wbit;

    logic                    tag_we;
    logic [IDX_W-1:0]        tag_waddr;
    tag_entry_t              tag_wdata;
    tag_entry_t              tag_rdata;
    logic                    data_we;
    logic [31:0]             data_rdata;

    // During a fill the stores are looked up at the latched miss address.
    assign look_addr = (state_q == FILL) ? lat_addr_q : fetch_addr;

    v810_tagram #(.AW(IDX_W), .DW(TAG_W + 2)) u_tag_store (
        .clk   (clk),
        .we    (tag_we),
        .waddr (tag_waddr),
        .wdata (tag_wdata),
        .raddr (addr_idx(look_addr)),
        .rdata (tag_rdata)
    );

    v810_tagram #(.AW(IDX_W + 1), .DW(32)) u_data_store (
        .clk   (clk),
        .we    (data_we),
        .waddr (addr_didx(lat_addr_q)),
        .wdata (mem_data),
        .raddr (addr_didx(look_addr)),
        .rdata (data_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, hit detection, fill write-back and fetch response.
    always_comb begin
        state_d     = state_q;
        clr_pend_d  = clr_pend_q;
        start_fill  = 1'b0;
        hit         = 1'b0;
        ack         = 1'b0;
        fetch_ready = 1'b0;
        fetch_data  = '0;
        tag_we      = 1'b0;
        tag_waddr   = addr_idx(lat_addr_q);
        tag_wdata   = '0;
        data_we     = 1'b0;
        wbit        = '0;
        wbit[addr_word(lat_addr_q)] = 1'b1;

        case (state_q)
            CLEAR: begin
                tag_we     = 1'b1;
                tag_waddr  = clr_cnt_q;
                clr_pend_d = 1'b0;
                if (clr_cnt_q == IDX_W'(NUM_LINES - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                hit = cache_en & fetch_req
                    & (tag_rdata.tag == addr_tag(fetch_addr))
                    & tag_rdata.v[addr_word(fetch_addr)];
                if (hit) begin
                    fetch_ready = 1'b1;
                    fetch_data  = data_rdata;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (fetch_req && !hit) begin
                    state_d    = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                ack = mem_ack & mem_req;
                if (clr_req) begin
                    clr_pend_d = 1'b1;
                end
                if (ack) begin
                    fetch_ready = fetch_req;
                    fetch_data  = mem_data;
                    if (cache_en) begin
                        data_we       = 1'b1;
                        tag_we        = 1'b1;
                        tag_wdata.tag = addr_tag(lat_addr_q);
                        tag_wdata.v   = (tag_rdata.tag == addr_tag(lat_addr_q))
                                      ? (tag_rdata.v | wbit) : wbit;
                    end
                    state_d = (clr_pend_q | clr_req) ? CLEAR : IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Sweep counter, pending clear, busy flag and memory request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_q  <= '0;
            clr_pend_q <= 1'b0;
            clr_busy   <= 1'b1;
            lat_addr_q <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            clr_cnt_q  <= (state_q == CLEAR) ? clr_cnt_q + IDX_W'(1) : '0;
            clr_pend_q <= clr_pend_d;
            clr_busy   <= (state_d == CLEAR) | clr_pend_d;
            if (start_fill) begin
                lat_addr_q <= fetch_addr;
                mem_req    <= 1'b1;
                mem_addr   <= fetch_addr;
            end else if (ack) begin
                mem_req    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_v810_icache_ctl.sv
// Directed bench for v810_icache_ctl with immediate-assertion checks.
module tb_v810_icache_ctl;

    logic        clk;
    logic        reset;
    logic        cache_en;
    logic        clr_req;
    logic        clr_busy;
    logic        fetch_req;
    logic [29:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int tests;
    int fails;

    v810_icache_ctl dut (
        .clk         (clk),
        .reset       (reset),
        .cache_en    (cache_en),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts negedge samples with clr_busy high; flags any fetch_ready seen meanwhile.
    task automatic sweep_len(output int n, output logic rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (clr_busy === 1'b1 && n < 1000) begin
            n++;
            if (fetch_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
            #1;
        end
    endtask

    // Fetch expected to hit: ready in the request cycle, no bus activity.
    task automatic do_hit(input string tag, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        chk({tag, "_ready"}, 32'(fetch_ready), 32'd1);
        chk({tag, "_data"}, fetch_data, d);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk({tag, "_nomemreq"}, 32'(mem_req), 32'd0);
    endtask

    // Fetch expected to miss; bus acks after wait_n request cycles.
    task automatic do_fill(input string tag, input logic [29:0] a, input logic [31:0] d,
                           input int wait_n);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        chk({tag, "_miss"}, 32'(fetch_ready), 32'd0);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
                chk({tag, "_memaddr"}, 32'(mem_addr), 32'(a));
                chk({tag, "_noready"}, 32'(fetch_ready), 32'd0);
            end
        end
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = d;
        #1;
        chk({tag, "_ackready"}, 32'(fetch_ready), 32'd1);
        chk({tag, "_ackdata"}, fetch_data, d);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_data  = '0;
        fetch_req = 1'b0;
        #1;
        chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
    endtask

    localparam logic [29:0] A1000 = 30'h400;
    localparam logic [29:0] A1004 = 30'h401;
    localparam logic [29:0] A1400 = 30'h500;
    localparam logic [29:0] A2000 = 30'h800;

    initial begin
        int   n;
        logic rdy_seen;
        tests = 0;
        fails = 0;
        reset      = 1'b1;
        cache_en   = 1'b1;
        clr_req    = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        mem_ack    = 1'b0;
        mem_data   = '0;

        // Reset values, then the power-on sweep with a fetch held pending.
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(clr_busy), 32'd1);
        chk("rst_ready", 32'(fetch_ready), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_memaddr", 32'(mem_addr), 32'd0);
        reset      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = A1000;
        sweep_len(n, rdy_seen);
        chk("sweep_len", 32'(n), 32'd128);
        chk("sweep_noready", 32'(rdy_seen), 32'd0);
        chk("idle_miss", 32'(fetch_ready), 32'd0);
        fetch_req = 1'b0;

        // Basic miss fill then hit.
        do_fill("f1000", A1000, 32'hDEAD_BEEF, 3);
        do_hit("h1000", A1000, 32'hDEAD_BEEF);

        // Other word of the same line misses, then both words hit.
        do_fill("f1004", A1004, 32'h1111_0004, 1);
        do_hit("h1004", A1004, 32'h1111_0004);
        do_hit("h1000b", A1000, 32'hDEAD_BEEF);

        // Conflicting tag replaces the line and drops the old valid bits.
        do_fill("f1400", A1400, 32'h5555_1400, 2);
        do_hit("h1400", A1400, 32'h5555_1400);
        do_fill("f1000r", A1000, 32'hDEAD_BEEF, 0);
        do_hit("h1000c", A1000, 32'hDEAD_BEEF);

        // Clear pulsed during a fill: fill completes, then a full sweep.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = A1004;
        #1;
        chk("cf_miss", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        clr_req = 1'b1;
        #1;
        chk("cf_memreq", 32'(mem_req), 32'd1);
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        chk("cf_busy", 32'(clr_busy), 32'd1);
        chk("cf_noready", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = 32'hCAFE_F00D;
        #1;
        chk("cf_ackready", 32'(fetch_ready), 32'd1);
        chk("cf_ackdata", fetch_data, 32'hCAFE_F00D);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_data  = '0;
        fetch_req = 1'b0;
        #1;
        chk("cf_reqdrop", 32'(mem_req), 32'd0);
        sweep_len(n, rdy_seen);
        chk("cf_sweep_len", 32'(n), 32'd128);
        do_fill("cf_f1000", A1000, 32'h0BAD_1000, 1);

        // Clear in IDLE alongside a hit: the hit still completes.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = A1000;
        clr_req    = 1'b1;
        #1;
        chk("ci_hitready", 32'(fetch_ready), 32'd1);
        chk("ci_hitdata", fetch_data, 32'h0BAD_1000);
        @(negedge clk);
        clr_req   = 1'b0;
        fetch_req = 1'b0;
        #1;
        sweep_len(n, rdy_seen);
        chk("ci_sweep_len", 32'(n), 32'd128);
        do_fill("ci_f1000", A1000, 32'h7777_1000, 1);

        // Disabled cache: bypass reads, no tag writes, lines survive the toggle.
        cache_en = 1'b0;
        do_fill("byp1", A2000, 32'h2000_0001, 1);
        do_fill("byp2", A2000, 32'h2000_0002, 0);
        cache_en = 1'b1;
        do_hit("h1000d", A1000, 32'h7777_1000);
        do_fill("en2000", A2000, 32'h2000_0003, 1);
        do_hit("h2000", A2000, 32'h2000_0003);

        // Reset mid-fill drops mem_req at once and restarts the sweep.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = A1000;
        @(negedge clk);
        #1;
        chk("rf_memreq", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rf_memreq_drop", 32'(mem_req), 32'd0);
        chk("rf_busy", 32'(clr_busy), 32'd1);
        chk("rf_ready", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        fetch_req = 1'b0;
        #1;
        sweep_len(n, rdy_seen);
        chk("rf_sweep_len", 32'(n), 32'd128);
        do_fill("rf_f2000", A2000, 32'h2000_0004, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/v810_icache_ctl.md
Name: v810_icache_ctl

Overview:
- Controller for the V810 instruction cache: direct-mapped, 2^IDX_W lines of 8 bytes, one valid bit per 32-bit word.
- Sequences a tag store and a data store, both built from the existing asynchronous-read tag RAM module.
- Serves CPU fetches with a zero-wait hit path, runs single-word miss fills over a request/acknowledge memory port, and performs whole-cache invalidation on reset and on CHCW clear commands.

Parameters:
- IDX_W, 7, line index width (128 lines, 1 KB).
- TAG_W, 32-IDX_W-3 (22), tag width; address bits [31:IDX_W+3].

Ports:
- clk  in  1  single clock; also drives the write clock of both RAMs.
- reset  in  1  asynchronous, active-high.
- cache_en  in  1  CHCW ICE; 0 = bypass (no lookups, no fills).
- clr_req  in  1  one-cycle pulse requesting invalidation of all lines (CHCW ICC).
- clr_busy  out  1  high while an invalidation sweep is running or pending.
- fetch_req  in  1  CPU fetch request; held until fetch_ready.
- fetch_addr  in  30  word address [31:2]; stable while fetch_req is high.
- fetch_ready  out  1  fetch completes this cycle.
- fetch_data  out  32  instruction word; valid when fetch_ready is high.
- mem_req  out  1  bus read request.
- mem_addr  out  30  bus word address.
- mem_ack  in  1  bus read data valid; one cycle.
- mem_data  in  32  bus read data.

Behaviour:
- Storage:
  - Tag entry {tag[TAG_W-1:0], v[1:0]}, width TAG_W+2. Read index fetch_addr[IDX_W+2:3]; word select fetch_addr[2].
  - Data RAM: 2^(IDX_W+1) x 32, indexed by fetch_addr[IDX_W+2:2].
- Reset:
  - FSM enters CLEAR with sweep counter 0.
  - All outputs 0 except clr_busy=1.
  - mem_req deasserts immediately on reset, including mid-fill. No memory handshake is owed afterwards.
- FSM states:
  - CLEAR:
    - Each cycle writes tag entry 0 at the counter index; counter increments.
    - Exits to IDLE after index 2^IDX_W-1 is written, i.e. exactly 2^IDX_W cycles.
    - fetch_ready stays 0 throughout.
    - clr_req arriving during CLEAR is absorbed; the sweep is not restarted.
  - IDLE:
    - Hit = cache_en & fetch_req & stored tag == fetch_addr[31:IDX_W+3] & v[fetch_addr[2]].
    - On hit, fetch_ready=1 in the same cycle, with fetch_data taken combinationally from the data RAM. State is unchanged.
    - On fetch_req without a hit: latch the address, go to FILL.
    - clr_req in IDLE (with or without fetch_req): go to CLEAR next cycle. clr_req has priority over a miss; a hit in the same cycle still completes.
  - FILL:
    - mem_req=1 and mem_addr = latched address, both registered, starting the cycle after entry.
    - On mem_ack: fetch_ready=1 and fetch_data=mem_data in the same cycle; mem_req drops next cycle.
    - If cache_en=1 at ack, write the data word and write the tag entry:
      - Stored tag matches: v |= word bit.
      - Stored tag differs: tag replaced, v = word bit only.
    - If cache_en=0 at ack, nothing is written.
    - Next state: CLEAR if a clear is pending, else IDLE.
    - clr_req during FILL sets a pending flag (clr_busy=1); the fill completes before the sweep.
- Misses on a disabled cache:
  - A fetch with cache_en=0 always misses and goes through FILL as a bypass read.
  - Toggling cache_en does not invalidate lines.
- Latency:
  - Hit: 0 wait states.
  - Miss: entry cycle + mem_req cycles + ack cycle. fetch_ready never precedes mem_ack.
- Reads during fill writes: the tag RAM read-during-write is don't-care. The FSM never performs a lookup in the cycle a tag write occurs (IDLE follows the write cycle), so no hazard.
- fetch_ready is never asserted without fetch_req.
- At most one memory request is outstanding.

Decomposition:
- Package v810_icache_pkg:
  - state enum {CLEAR, IDLE, FILL};
  - localparams LINE_BYTES=8 and WORDS_PER_LINE=2;
  - tag-entry struct {tag, v};
  - index, tag and word-select extraction functions.
- Sub-modules: two instances of v810_tagram (tag store, data store). No new sub-module; FSM, sweep counter and pending flag stay in v810_icache_ctl.

Test Plan:
- Reset release -> clr_busy=1 for exactly 128 cycles and fetch_ready=0 throughout; then clr_busy=0 and state IDLE.
- cache_en=1, fetch 0x0000_1000 (miss), mem_ack after 3 cycles with 0xDEAD_BEEF -> fetch_ready with that data on the ack cycle. Refetch -> fetch_ready=1 in the request cycle, data 0xDEAD_BEEF, no mem_req.
- Fetch 0x1000 filled, then 0x1004 (same line, other word) -> second fetch misses and fills. Then both hit.
- Fetch 0x1000 filled, then 0x1400 (same index, different tag) fill -> 0x1400 hits; 0x1000 misses again (its valid bit was dropped).
- clr_req pulsed during a pending FILL -> fill completes with correct data, clr_busy=1 from the pulse, then a 128-cycle sweep; 0x1000 misses afterwards.
- cache_en=0, fetch 0x2000 twice -> two mem_req transactions, no tag writes. Set cache_en=1 and fetch 0x2000 -> miss.
